digseg_mux: RTL and testbench
=============================

Name: digseg_mux

Overview:
- Wishbone-style slave that drives a time-multiplexed bank of NUM_DIGITS common-anode/cathode seven-segment digits from one shared segment bus.
- Holds one 4-bit hex nibble per digit, plus per-digit blank and decimal-point masks.
- Scans the digits with a programmable slot time and dead time for ghost suppression.
- Sits on the peripheral bus beside the other memory-mapped I/O.

Parameters:
- NUM_DIGITS, 8: number of digits scanned; legal range 1..8.
- SCAN_DIV, 50000: clock cycles per digit slot; minimum 2.
- DEAD_CYCLES, 2: cycles at the end of each slot with all digit selects off; must be less than SCAN_DIV.
- SEG_ACTIVE_LOW, 0: when 1, seg_o and dig_sel_o are inverted at the output registers.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: asynchronous, active-low reset.
- bus_addr_i, input, 32: byte address; only bits [3:2] are decoded.
- bus_data_i, input, 32: write data.
- bus_data_o, output, 32: read data.
- bus_select_i, input, 1: slave select (cycle request).
- bus_we_i, input, 1: 1 = write, 0 = read.
- bus_ack_o, output, 1: transfer acknowledge.
- seg_o, output, 8: segments; bit 7 = dp, bits [6:0] = g..a.
- dig_sel_o, output, NUM_DIGITS: one-hot digit enable.

Behaviour:
- Reset (rst low, asynchronous):
  - DATA = 0, CTRL = 0.
  - Scan counter = 0, scan index = 0.
  - bus_ack_o = 0, bus_data_o = 0.
  - seg_o and dig_sel_o at their inactive level: all 0, or all 1 if SEG_ACTIVE_LOW.
  - Reset mid-transaction drops the ack and discards the write.
- Register map, by bus_addr_i[3:2]:
  - 0 DATA (RW): nibble k in bits [4k+3:4k] drives digit k. Bits for k ≥ NUM_DIGITS are stored but not displayed.
  - 1 CTRL (RW): bit0 = enable; bits [15:8] = blank mask (1 = digit dark); bits [23:16] = dp mask (1 = dp lit). Other bits read 0.
  - 2 STATUS (RO): bits [2:0] = current scan index; bit 8 = dead-time flag. Writes ignored.
  - 3: reads 0, writes ignored. Still acked.
- Handshake:
  - A transfer starts on any cycle where bus_select_i = 1 and bus_ack_o = 0.
  - On the next edge bus_ack_o goes to 1 for exactly one cycle.
  - A write commits on that same edge.
  - A read loads bus_data_o on that edge; bus_data_o holds its value until the next read.
  - If select is held continuously, acks occur every other cycle.
  - bus_we_i and bus_addr_i are sampled in the request cycle.
- Scan engine (runs only while CTRL.enable = 1):
  - Counter runs 0..SCAN_DIV-1.
  - At SCAN_DIV-1 the counter wraps to 0 and the index advances modulo NUM_DIGITS (wrap from NUM_DIGITS-1 to 0).
  - The digit is active while counter < SCAN_DIV-DEAD_CYCLES; otherwise all dig_sel are off and the dead flag = 1.
  - For an active digit k: seg = {dpmask[k], hex(nibble k)}.
  - A blanked digit gives seg = 0 but keeps dig_sel[k] asserted, so the scan timing is unchanged.
- Output timing: seg_o and dig_sel_o are registered and lag the counter/index state by one cycle.
- Hex table (g..a): 0 3F, 1 06, 2 5B, 3 4F, 4 66, 5 6D, 6 7D, 7 07, 8 7F, 9 6F, A 77, b 7C, C 39, d 5E, E 79, F 71.
- Disable (write enable = 0): counter and index clear to 0 on the committing edge; outputs go inactive on the following edge.
- Enable (0→1): the scan starts at digit 0, count 0.
- A DATA or CTRL write mid-slot takes effect on the output register the cycle after commit; there is no slot restart.
- NUM_DIGITS = 1: index stays 0 and dig_sel toggles only for the dead time.

Decomposition:
- defines.v gains:
  - DigSegMux register offsets;
  - CTRL field positions;
  - DigSegSegBus [7:0];
  - default parameter values.
- One natural sub-module, digseg_hex7: a combinational 4-bit → 7-bit decoder instantiated once on the selected nibble.

Test Plan:
- Reset, then no access → seg_o = 00, dig_sel_o = 00, bus_ack_o = 0; read CTRL → 00000000 with a single ack cycle.
- Run with SCAN_DIV = 4, DEAD_CYCLES = 1, NUM_DIGITS = 4:
  - Stimulus: write DATA = 0000_3210, then CTRL = 0x0000_0001.
  - Required: dig_sel cycles 1,2,4,8 with each digit high for 3 cycles and 1 cycle all-zero; seg = 3F, 06, 5B, 4F; index wraps 3→0.
- Masks: CTRL = 0x0002_0401 → digit 2 dark (seg 00 while dig_sel = 4), digit 1 seg = 86.
- Held select with back-to-back reads of STATUS → ack pattern 0,1,0,1; index bits match the observed dig_sel.
- Write CTRL = 0 mid-slot → outputs inactive 2 cycles after the request; re-enable → the first dig_sel = 1.
- SEG_ACTIVE_LOW = 1 with DATA nibble 8 → seg_o = 80 and the active dig_sel bit low; assert rst mid-scan → outputs go to all-ones immediately (asynchronously).

Source files
------------

// File: rtl/digseg_mux_pkg.sv
// Shared register map, CTRL/STATUS field positions and default sizing for the
// seven-segment scan multiplexer.
package digseg_mux_pkg;

   typedef enum logic [1:0] {
      REG_DATA   = 2'd0,
      REG_CTRL   = 2'd1,
      REG_STATUS = 2'd2,
      REG_RSVD   = 2'd3
   } reg_sel_e;

   localparam int unsigned CTRL_EN_BIT    = 0;
   localparam int unsigned CTRL_BLANK_LSB = 8;
   localparam int unsigned CTRL_DP_LSB    = 16;
   localparam int unsigned STAT_IDX_LSB   = 0;
   localparam int unsigned STAT_DEAD_BIT  = 8;

   typedef logic [7:0] seg_bus_t;

   typedef struct packed {
      logic [7:0] dp;
      logic [7:0] blank;
      logic       en;
   } ctrl_t;

   localparam int unsigned DEF_NUM_DIGITS     = 8;
   localparam int unsigned DEF_SCAN_DIV       = 50000;
   localparam int unsigned DEF_DEAD_CYCLES    = 2;
   localparam bit          DEF_SEG_ACTIVE_LOW = 1'b0;

endpackage

// File: rtl/digseg_mux_hex7.sv
// Combinational hex nibble to seven-segment (g..a) decoder.
module digseg_hex7 (
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   always_comb begin
      seg = '0;
      case (nibble)
         4'h0: seg = 7'h3F;
         4'h1: seg = 7'h06;
         4'h2: seg = 7'h5B;
         4'h3: seg = 7'h4F;
         4'h4: seg = 7'h66;
         4'h5: seg = 7'h6D;
         4'h6: seg = 7'h7D;
         4'h7: seg = 7'h07;
         4'h8: seg = 7'h7F;
         4'h9: seg = 7'h6F;
         4'hA: seg = 7'h77;
         4'hB: seg = 7'h7C;
         4'hC: seg = 7'h39;
         4'hD: seg = 7'h5E;
         4'hE: seg = 7'h79;
         4'hF: seg = 7'h71;
         default: seg = '0;
      endcase
   end

endmodule

// File: rtl/digseg_mux.sv
// Bus-mapped time-multiplexed seven-segment driver: DATA/CTRL/STATUS registers,
// slot/dead-time scan engine and registered segment/digit outputs.
module digseg_mux
   import digseg_mux_pkg::*;
#(
   parameter int unsigned NUM_DIGITS     = DEF_NUM_DIGITS,
   parameter int unsigned SCAN_DIV       = DEF_SCAN_DIV,
   parameter int unsigned DEAD_CYCLES    = DEF_DEAD_CYCLES,
   parameter bit          SEG_ACTIVE_LOW = DEF_SEG_ACTIVE_LOW
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [31:0]           bus_addr_i,
   input  logic [31:0]           bus_data_i,
   output logic [31:0]           bus_data_o,
   input  logic                  bus_select_i,
   input  logic                  bus_we_i,
   output logic                  bus_ack_o,
   output logic [7:0]            seg_o,
   output logic [NUM_DIGITS-1:0] dig_sel_o
);

   localparam int unsigned         CNT_W      = $clog2(SCAN_DIV);
   localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0]    ACTIVE_END = CNT_W'(SCAN_DIV - DEAD_CYCLES);
   localparam logic [2:0]          IDX_LAST   = 3'(NUM_DIGITS - 1);
   localparam seg_bus_t            SEG_OFF    = {8{SEG_ACTIVE_LOW}};
   localparam logic [NUM_DIGITS-1:0] DIG_OFF  = {NUM_DIGITS{SEG_ACTIVE_LOW}};

   logic [31:0]           data_q;
   ctrl_t                 ctrl_q;
   logic                  ack_q;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [2:0]            idx_q, idx_d;

   reg_sel_e              reg_sel;
   logic                  req, wr_data, wr_ctrl, rd_req;
   logic                  dead;
   logic [31:0]           rd_val;
   logic [3:0]            nibble;
   logic [6:0]            hex_seg;
   seg_bus_t              seg_raw;
   logic [NUM_DIGITS-1:0] dig_raw;
   logic                  unused_addr;

   assign unused_addr = ^{bus_addr_i[31:4], bus_addr_i[1:0]};

   // Bus decode: a request is any selected cycle not already being acked.
   assign reg_sel = reg_sel_e'(bus_addr_i[3:2]);
   assign req     = bus_select_i & ~ack_q;
   assign rd_req  = req & ~bus_we_i;
   assign wr_data = req & bus_we_i & (reg_sel == REG_DATA);
   assign wr_ctrl = req & bus_we_i & (reg_sel == REG_CTRL);

   assign dead    = (DEAD_CYCLES != 0) && (cnt_q >= ACTIVE_END);

   always_comb begin
      rd_val = '0;
      case (reg_sel)
         REG_DATA: rd_val = data_q;
         REG_CTRL: begin
            rd_val[CTRL_EN_BIT]         = ctrl_q.en;
            rd_val[CTRL_BLANK_LSB +: 8] = ctrl_q.blank;
            rd_val[CTRL_DP_LSB +: 8]    = ctrl_q.dp;
         end
         REG_STATUS: begin
            rd_val[STAT_IDX_LSB +: 3] = idx_q;
            rd_val[STAT_DEAD_BIT]     = dead;
         end
         REG_RSVD: rd_val = '0;
         default:  rd_val = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ack_q      <= 1'b0;
         bus_data_o <= '0;
         data_q     <= '0;
         ctrl_q     <= '0;
      end else begin
         ack_q <= req;
         if (rd_req) begin
            bus_data_o <= rd_val;
         end
         if (wr_data) begin
            data_q <= bus_data_i;
         end
         if (wr_ctrl) begin
            ctrl_q.en    <= bus_data_i[CTRL_EN_BIT];
            ctrl_q.blank <= bus_data_i[CTRL_BLANK_LSB +: 8];
            ctrl_q.dp    <= bus_data_i[CTRL_DP_LSB +: 8];
         end
      end
   end

   assign bus_ack_o = ack_q;

   // A disabling CTRL write clears the scan position on its commit edge,
   // so a later enable always restarts at digit 0, count 0.
   always_comb begin
      cnt_d = cnt_q;
      idx_d = idx_q;
      if (ctrl_q.en) begin
         if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
      if (wr_ctrl && !bus_data_i[CTRL_EN_BIT]) begin
         cnt_d = '0;
         idx_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
         idx_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         idx_q <= idx_d;
      end
   end

   assign nibble = data_q[{idx_q, 2'b00} +: 4];

   digseg_hex7 u_hex7 (
      .nibble (nibble),
      .seg    (hex_seg)
   );

   always_comb begin
      seg_raw = '0;
      dig_raw = '0;
      if (ctrl_q.en && !dead) begin
         for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            dig_raw[k] = (32'(idx_q) == k);
         end
         seg_raw = ctrl_q.blank[idx_q] ? 8'h00 : {ctrl_q.dp[idx_q], hex_seg};
      end
   end

   // Polarity is applied at the output flops so reset lands on the dark level.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         seg_o     <= SEG_OFF;
         dig_sel_o <= DIG_OFF;
      end else begin
         seg_o     <= seg_raw ^ SEG_OFF;
         dig_sel_o <= dig_raw ^ DIG_OFF;
      end
   end

endmodule

// File: tb/tb_digseg_mux.sv
// Randomized self-checking bench for digseg_mux: an active-high and an
// active-low instance share one bus and are checked against a scan-time model.
module tb_digseg_mux;

   localparam int ND = 4;
   localparam int SD = 4;
   localparam int DC = 1;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] bus_addr  = '0;
   logic [31:0] bus_wdata = '0;
   logic        bus_sel   = 1'b0;
   logic        bus_we    = 1'b0;

   logic [31:0] rdata_a, rdata_b;
   logic        ack_a, ack_b;
   logic [7:0]  seg_a, seg_b;
   logic [ND-1:0] dig_a, dig_b;

   int n_checks = 0;
   int n_err    = 0;
   bit chk_on   = 1'b0;

   digseg_mux #(
      .NUM_DIGITS     (ND),
      .SCAN_DIV       (SD),
      .DEAD_CYCLES    (DC),
      .SEG_ACTIVE_LOW (1'b0)
   ) u_dut_hi (
      .clk          (clk),
      .rst          (rst),
      .bus_addr_i   (bus_addr),
      .bus_data_i   (bus_wdata),
      .bus_data_o   (rdata_a),
      .bus_select_i (bus_sel),
      .bus_we_i     (bus_we),
      .bus_ack_o    (ack_a),
      .seg_o        (seg_a),
      .dig_sel_o    (dig_a)
   );

   digseg_mux #(
      .NUM_DIGITS     (ND),
      .SCAN_DIV       (SD),
      .DEAD_CYCLES    (DC),
      .SEG_ACTIVE_LOW (1'b1)
   ) u_dut_lo (
      .clk          (clk),
      .rst          (rst),
      .bus_addr_i   (bus_addr),
      .bus_data_i   (bus_wdata),
      .bus_data_o   (rdata_b),
      .bus_select_i (bus_sel),
      .bus_we_i     (bus_we),
      .bus_ack_o    (ack_b),
      .seg_o        (seg_b),
      .dig_sel_o    (dig_b)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // Reference model: scan position is derived from the number of enabled
   // cycles elapsed, t, as count = t mod SD and digit = (t div SD) mod ND.
   logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   int          m_t, m_next_t, m_cnt, m_idx;
   bit          m_dead, m_req, m_ack, m_en;
   logic [31:0] m_data, m_rdata;
   logic [7:0]  m_blank, m_dp, m_seg, m_seg_n;
   logic [3:0]  m_dig, m_dig_n, m_nib;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_t = 0; m_ack = 0; m_en = 0; m_data = '0; m_rdata = '0;
         m_blank = '0; m_dp = '0; m_seg = '0; m_dig = '0;
         m_seg_n = 8'hFF; m_dig_n = 4'hF;
      end else begin
         m_cnt  = m_t % SD;
         m_idx  = (m_t / SD) % ND;
         m_dead = (m_cnt >= SD - DC);
         if (m_en && !m_dead) begin
            m_dig = 4'b0001 << m_idx;
            m_nib = m_data[m_idx*4 +: 4];
            m_seg = m_blank[m_idx] ? 8'h00 : {m_dp[m_idx], hex_tab[m_nib]};
         end else begin
            m_dig = '0;
            m_seg = '0;
         end
         m_seg_n = ~m_seg;
         m_dig_n = ~m_dig;
         m_req    = bus_sel && !m_ack;
         m_ack    = m_req;
         m_next_t = m_en ? m_t + 1 : 0;
         if (m_req && !bus_we) begin
            case (bus_addr[3:2])
               2'd0:    m_rdata = m_data;
               2'd1:    m_rdata = {8'h00, m_dp, m_blank, 7'h00, m_en};
               2'd2:    m_rdata = {23'h0, m_dead, 5'h0, 3'(m_idx)};
               default: m_rdata = '0;
            endcase
         end
         if (m_req && bus_we) begin
            case (bus_addr[3:2])
               2'd0: m_data = bus_wdata;
               2'd1: begin
                  m_en    = bus_wdata[0];
                  m_blank = bus_wdata[15:8];
                  m_dp    = bus_wdata[23:16];
                  if (!bus_wdata[0]) m_next_t = 0;
               end
               default: ;
            endcase
         end
         m_t = m_next_t;
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         check("ack_hi",   ack_a,   m_ack);
         check("seg_hi",   seg_a,   m_seg);
         check("dig_hi",   dig_a,   m_dig);
         check("rdata_hi", rdata_a, m_rdata);
         check("ack_lo",   ack_b,   m_ack);
         check("seg_lo",   seg_b,   m_seg_n);
         check("dig_lo",   dig_b,   m_dig_n);
         check("rdata_lo", rdata_b, m_rdata);
      end
   end

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      bus_sel = 1'b1; bus_we = 1'b1; bus_addr = a; bus_wdata = d;
      @(negedge clk);
      check("wr_ack", ack_a, 32'd1);
      bus_sel = 1'b0; bus_we = 1'b0;
   endtask

   task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
      @(negedge clk);
      bus_sel = 1'b1; bus_we = 1'b0; bus_addr = a;
      @(negedge clk);
      check("rd_ack", ack_a, 32'd1);
      d = rdata_a;
      bus_sel = 1'b0;
   endtask

   logic [3:0] seq_dig [20] = '{4'h1, 4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h2, 4'h0, 4'h4, 4'h4,
                                4'h4, 4'h0, 4'h8, 4'h8, 4'h8, 4'h0, 4'h1, 4'h1, 4'h1, 4'h0};
   logic [7:0] seq_seg [20] = '{8'h3F, 8'h3F, 8'h3F, 8'h00, 8'h06, 8'h06, 8'h06, 8'h00, 8'h5B, 8'h5B,
                                8'h5B, 8'h00, 8'h4F, 8'h4F, 8'h4F, 8'h00, 8'h3F, 8'h3F, 8'h3F, 8'h00};

   initial begin
      logic [31:0] r;
      bit seen1, seen2;

      #1 rst = 1'b0;
      chk_on = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_seg_hi", seg_a, 32'h00);
      check("rst_dig_hi", dig_a, 32'h0);
      check("rst_ack",    ack_a, 32'd0);
      check("rst_rdata",  rdata_a, 32'h0);
      check("rst_seg_lo", seg_b, 32'hFF);
      check("rst_dig_lo", dig_b, 32'hF);
      @(negedge clk);
      #2 rst = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_ack", ack_a, 32'd0);

      bus_read(32'h4, r);
      check("ctrl_after_rst", r, 32'h0);
      @(negedge clk);
      check("ack_single", ack_a, 32'd0);

      bus_write(32'h0, 32'h0000_3210);
      bus_write(32'h4, 32'h0000_0001);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("scan_dig",   dig_a, seq_dig[i]);
         check("scan_seg",   seg_a, seq_seg[i]);
         check("model_dig",  m_dig, seq_dig[i]);
      end

      bus_write(32'h4, 32'h0002_0401);
      seen1 = 0; seen2 = 0;
      for (int i = 0; i < 40 && !(seen1 && seen2); i++) begin
         @(negedge clk);
         if (dig_a == 4'h4 && !seen2) begin
            check("blank_seg", seg_a, 32'h00);
            seen2 = 1;
         end
         if (dig_a == 4'h2 && !seen1) begin
            check("dp_seg", seg_a, 32'h86);
            seen1 = 1;
         end
      end
      check("mask_digits_seen", {30'd0, seen1, seen2}, 32'h3);

      @(negedge clk);
      bus_sel = 1'b1; bus_we = 1'b0; bus_addr = 32'h8;
      check("hold_ack", ack_a, 32'd0);
      for (int i = 1; i <= 6; i++) begin
         @(negedge clk);
         check("hold_ack", ack_a, 32'(i % 2));
         if (ack_a) begin
            if (rdata_a[8]) check("status_dead_dig", dig_a, 32'h0);
            else            check("status_idx_dig", dig_a, 32'd1 << rdata_a[2:0]);
         end
      end
      bus_sel = 1'b0;

      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         bus_sel   = 1'($urandom_range(0, 1));
         bus_we    = 1'($urandom_range(0, 1));
         bus_addr  = $urandom;
         bus_wdata = $urandom;
         if (bus_we && bus_addr[3:2] == 2'd1) bus_wdata[0] = ($urandom_range(0, 7) != 0);
      end
      @(negedge clk);
      bus_sel = 1'b0; bus_we = 1'b0;
      repeat (2) @(negedge clk);

      bus_write(32'h4, 32'h1);
      repeat (5) @(negedge clk);
      bus_write(32'h4, 32'h0);
      @(negedge clk);
      check("dis_dig_hi", dig_a, 32'h0);
      check("dis_seg_hi", seg_a, 32'h0);
      check("dis_dig_lo", dig_b, 32'hF);
      bus_write(32'h4, 32'h1);
      check("reen_pre_dig", dig_a, 32'h0);
      @(negedge clk);
      check("reen_first_dig", dig_a, 32'h1);

      bus_write(32'h4, 32'h0);
      bus_write(32'h0, 32'h8);
      bus_write(32'h4, 32'h1);
      @(negedge clk);
      check("al_seg_lo", seg_b, 32'h80);
      check("al_dig_lo", dig_b, 32'hE);
      check("al_seg_hi", seg_a, 32'h7F);
      check("al_dig_hi", dig_a, 32'h1);
      @(posedge clk);
      #1 check("pre_rst_dig_lo", dig_b, 32'hE);
      #1 rst = 1'b0;
      #1;
      check("async_seg_lo", seg_b, 32'hFF);
      check("async_dig_lo", dig_b, 32'hF);
      check("async_seg_hi", seg_a, 32'h00);
      check("async_dig_hi", dig_a, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      bus_read(32'h0, r);
      check("data_after_rst", r, 32'h0);

      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
